// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI state encoding, default frequencies and divider helper
package spi_pkg;

  localparam int DEFAULT_CLOCK_FREQUENCY = 27000000;
  localparam int DEFAULT_SPI_FREQUENCY   = 1000000;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SCK_HIGH,
    SCK_LOW,
    HOLD,
    FINISH
  } spi_state_e;

  function automatic int calc_half_div(input int clk_hz, input int spi_hz);
    int d;
    d = clk_hz / (2 * spi_hz);
    return (d < 1) ? 1 : d;
  endfunction

endpackage

// File: rtl/spi_clk_div.sv
// rtl/spi_clk_div.sv - half-period divider: counts 0..HALF_DIV-1, pulses tick on terminal count
module spi_clk_div #(
  parameter int HALF_DIV = 13
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);

  localparam int CW = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = !restart && (cnt == CW'(HALF_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (restart || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_master.sv
// rtl/spi_master.sv - mode-0 SPI byte master; SPI_MASTER_CS_HOLD_EN adds hold_cs to keep CS low between bytes
module spi_master
  import spi_pkg::*;
#(
  parameter int CLOCK_FREQUENCY = DEFAULT_CLOCK_FREQUENCY,
  parameter int SPI_FREQUENCY   = DEFAULT_SPI_FREQUENCY
) (
  input  logic       system_clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] tx_data,
`ifdef SPI_MASTER_CS_HOLD_EN
  input  logic       hold_cs,
`endif
  output logic       busy,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       spi_sck,
  output logic       spi_cs,
  output logic       spi_mosi,
  input  logic       spi_miso
);

  localparam int HALF_DIV = calc_half_div(CLOCK_FREQUENCY, SPI_FREQUENCY);

  spi_state_e state, state_n;
  logic [7:0] shreg, shreg_n;
  logic [2:0] bit_cnt, bit_cnt_n;
  logic       sck_n, cs_n, mosi_n, busy_n, rx_valid_n;
  logic [7:0] rx_data_n;
  logic       restart, tick;

`ifdef SPI_MASTER_CS_HOLD_EN
  logic keep_cs, keep_cs_n;
  always_ff @(posedge system_clk or negedge rst_n) begin
    if (!rst_n) keep_cs <= 1'b0;
    else        keep_cs <= keep_cs_n;
  end
`else
  logic keep_cs;
  assign keep_cs = 1'b0;
`endif

  spi_clk_div #(.HALF_DIV(HALF_DIV)) u_div (
    .clk     (system_clk),
    .rst_n   (rst_n),
    .restart (restart),
    .tick    (tick)
  );

  always_comb begin
    state_n    = state;
    shreg_n    = shreg;
    bit_cnt_n  = bit_cnt;
    sck_n      = spi_sck;
    cs_n       = spi_cs;
    mosi_n     = spi_mosi;
    busy_n     = busy;
    rx_valid_n = 1'b0;
    rx_data_n  = rx_data;
    restart    = 1'b0;
`ifdef SPI_MASTER_CS_HOLD_EN
    keep_cs_n  = keep_cs;
`endif
    case (state)
      IDLE: begin
        restart = 1'b1;
        if (start) begin
          state_n   = SETUP;
          shreg_n   = tx_data;
          bit_cnt_n = 3'd0;
          cs_n      = 1'b0;
          mosi_n    = tx_data[7];
          busy_n    = 1'b1;
`ifdef SPI_MASTER_CS_HOLD_EN
          keep_cs_n = hold_cs;
`endif
        end
      end
      // MISO enters at bit 0 as TX bits leave from bit 7, so one register serves both
      SETUP, SCK_LOW: begin
        if (tick) begin
          sck_n   = 1'b1;
          shreg_n = {shreg[6:0], spi_miso};
          state_n = SCK_HIGH;
        end
      end
      SCK_HIGH: begin
        if (tick) begin
          sck_n = 1'b0;
          if (bit_cnt != 3'd7) begin
            bit_cnt_n = bit_cnt + 3'd1;
            mosi_n    = shreg[7];
            state_n   = SCK_LOW;
          end else begin
            bit_cnt_n = 3'd0;
            state_n   = HOLD;
          end
        end
      end
      // Two half periods: the trailing SCK-low half, then the CS hold half
      HOLD: begin
        if (tick) begin
          if (bit_cnt == 3'd0) begin
            bit_cnt_n = 3'd1;
          end else begin
            bit_cnt_n = 3'd0;
            cs_n      = keep_cs ? 1'b0 : 1'b1;
            state_n   = FINISH;
          end
        end
      end
      FINISH: begin
        rx_data_n  = shreg;
        rx_valid_n = 1'b1;
        busy_n     = 1'b0;
        mosi_n     = 1'b0;
        restart    = 1'b1;
        state_n    = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge system_clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      shreg    <= 8'h00;
      bit_cnt  <= 3'd0;
      spi_sck  <= 1'b0;
      spi_cs   <= 1'b1;
      spi_mosi <= 1'b0;
      busy     <= 1'b0;
      rx_valid <= 1'b0;
      rx_data  <= 8'h00;
    end else begin
      state    <= state_n;
      shreg    <= shreg_n;
      bit_cnt  <= bit_cnt_n;
      spi_sck  <= sck_n;
      spi_cs   <= cs_n;
      spi_mosi <= mosi_n;
      busy     <= busy_n;
      rx_valid <= rx_valid_n;
      rx_data  <= rx_data_n;
    end
  end

endmodule
